// File: rtl/jk_seq_driver.sv
// jk_seq_driver: queues target states and drives one-cycle JK excitation to reach each, then verifies
//   clk/rst_n          : clock, async active-low reset
//   tgt_valid/tgt_data : target word offer; tgt_ready = FIFO not full
//   q_fb               : present Q of the flip-flop bank
//   jk                 : registered excitation, jk[2i+1]=J_i, jk[2i]=K_i
//   busy/done/err      : not idle / verified pulse / sticky mismatch
//   err_clr            : clears err and leaves ERR
module jk_seq_driver #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter bit TOGGLE = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tgt_valid,
  input  logic [WIDTH-1:0]   tgt_data,
  output logic               tgt_ready,
  input  logic [WIDTH-1:0]   q_fb,
  output logic [2*WIDTH-1:0] jk,
  output logic               busy,
  output logic               done,
  output logic               err,
  input  logic               err_clr
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, ERR} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic [WIDTH-1:0] tgt_q, tgt_d, head;
  logic [2*WIDTH-1:0] jk_q, jk_d, exc;
  logic done_q, done_d, err_q, err_d, full, empty, push, pop;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign push = tgt_valid && !full;
  assign pop = state_q == IDLE && !empty;
  assign head = mem_q[rd_q];
  assign tgt_ready = !full;
  assign jk = jk_q;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign err = err_q;
  // excitation is computed against the head word so it is ready on the popping edge
  for (genvar i = 0; i < WIDTH; i++) begin : g_exc
    assign exc[2*i+1] = (q_fb[i] ^ head[i]) & (head[i] | TOGGLE);
    assign exc[2*i]   = (q_fb[i] ^ head[i]) & (!head[i] | TOGGLE);
  end
  always_comb begin
    state_d = state_q;
    tgt_d = tgt_q;
    jk_d = '0;
    done_d = 1'b0;
    err_d = err_q;
    case (state_q)
      IDLE: if (!empty) begin
        state_d = DRIVE;
        tgt_d = head;
        jk_d = exc;
      end
      DRIVE: state_d = CHECK;
      CHECK: if (q_fb == tgt_q) begin
        done_d = 1'b1;
        state_d = IDLE;
      end else begin
        err_d = 1'b1;
        state_d = ERR;
      end
      ERR: if (err_clr) begin
        err_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tgt_q <= '0;
      jk_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      tgt_q <= tgt_d;
      jk_q <= jk_d;
      done_q <= done_d;
      err_q <= err_d;
      wr_q <= push ? wr_q + 1'b1 : wr_q;
      rd_q <= pop ? rd_q + 1'b1 : rd_q;
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= tgt_data;
  end
endmodule

// File: tb/tb_jk_seq_driver.sv
// tb_jk_seq_driver: directed checks of jk_seq_driver against a behavioural JK flip-flop bank
module tb_jk_seq_driver;
  logic clk = 1'b0;
  logic rst_n;
  logic v0, clr0, bld0, rdy0, busy0, done0, err0;
  logic [3:0] d0, bank0, bval0, stuck0, qfb0;
  logic [7:0] jk0;
  logic v1, bld1, rdy1, busy1, done1, err1;
  logic [3:0] d1, bank1, bval1;
  logic [7:0] jk1;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  assign qfb0 = bank0 & ~stuck0;
  jk_seq_driver #(.WIDTH(4), .DEPTH(4), .TOGGLE(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .tgt_valid(v0), .tgt_data(d0), .tgt_ready(rdy0),
    .q_fb(qfb0), .jk(jk0), .busy(busy0), .done(done0), .err(err0), .err_clr(clr0));
  jk_seq_driver #(.WIDTH(4), .DEPTH(4), .TOGGLE(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .tgt_valid(v1), .tgt_data(d1), .tgt_ready(rdy1),
    .q_fb(bank1), .jk(jk1), .busy(busy1), .done(done1), .err(err1), .err_clr(1'b0));
  function automatic logic [3:0] jk_apply(input logic [3:0] q, input logic [7:0] e);
    logic [3:0] r;
    for (int i = 0; i < 4; i++)
      case ({e[2*i+1], e[2*i]})
        2'b10: r[i] = 1'b1;
        2'b01: r[i] = 1'b0;
        2'b11: r[i] = ~q[i];
        default: r[i] = q[i];
      endcase
    return r;
  endfunction
  always @(posedge clk) begin
    bank0 <= bld0 ? bval0 : jk_apply(bank0, jk0);
    bank1 <= bld1 ? bval1 : jk_apply(bank1, jk1);
  end
  task automatic push0(input logic [3:0] w);
    v0 = 1'b1; d0 = w;
    @(negedge clk);
    v0 = 1'b0;
  endtask
  task automatic test_reset;
    total++; if ({rdy0, busy0, done0, err0, jk0} !== 12'b1000_0000_0000) begin bad++; $display("FAIL rst_state got=%b exp=%b", {rdy0, busy0, done0, err0, jk0}, 12'b1000_0000_0000); end
    rst_n = 1'b1;
    @(negedge clk);
    v0 = 1'b1; d0 = 4'b1111;
    @(negedge clk);
    d0 = 4'b0110;
    @(negedge clk);
    v0 = 1'b0;
    total++; if (jk0 !== 8'b10101010 || busy0 !== 1'b1) begin bad++; $display("FAIL rst_predrive jk=%b busy=%b exp jk=10101010 busy=1", jk0, busy0); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (jk0 !== 8'h00) begin bad++; $display("FAIL rst_async_jk got=%b exp=00000000", jk0); end
    @(negedge clk);
    total++; if (rdy0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0 || err0 !== 1'b0) begin bad++; $display("FAIL rst_held rdy=%b busy=%b done=%b err=%b exp 1 0 0 0", rdy0, busy0, done0, err0); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (busy0 !== 1'b0 || bank0 !== 4'b0000) begin bad++; $display("FAIL rst_flushed busy=%b bank=%b exp busy=0 bank=0000", busy0, bank0); end
  endtask
  task automatic test_basic;
    push0(4'b1010);
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL basic_idle busy=%b exp=0", busy0); end
    @(negedge clk);
    total++; if (jk0 !== 8'b10001000 || busy0 !== 1'b1) begin bad++; $display("FAIL basic_jk got=%b busy=%b exp=10001000 busy=1", jk0, busy0); end
    @(negedge clk);
    total++; if (jk0 !== 8'h00 || bank0 !== 4'b1010 || done0 !== 1'b0) begin bad++; $display("FAIL basic_check jk=%b bank=%b done=%b exp 00000000 1010 0", jk0, bank0, done0); end
    @(negedge clk);
    total++; if (done0 !== 1'b1 || err0 !== 1'b0) begin bad++; $display("FAIL basic_done done=%b err=%b exp 1 0", done0, err0); end
    @(negedge clk);
    total++; if (done0 !== 1'b0 || busy0 !== 1'b0) begin bad++; $display("FAIL basic_after done=%b busy=%b exp 0 0", done0, busy0); end
  endtask
  task automatic test_hold;
    push0(4'b1010);
    @(negedge clk);
    total++; if (jk0 !== 8'h00 || busy0 !== 1'b1) begin bad++; $display("FAIL hold_jk got=%b busy=%b exp=00000000 busy=1", jk0, busy0); end
    repeat (2) @(negedge clk);
    total++; if (done0 !== 1'b1 || bank0 !== 4'b1010) begin bad++; $display("FAIL hold_done done=%b bank=%b exp 1 1010", done0, bank0); end
    @(negedge clk);
  endtask
  task automatic test_toggle;
    bld1 = 1'b1; bval1 = 4'b1100;
    @(negedge clk);
    bld1 = 1'b0;
    v1 = 1'b1; d1 = 4'b0110;
    @(negedge clk);
    v1 = 1'b0;
    @(negedge clk);
    total++; if (jk1 !== 8'b11001100) begin bad++; $display("FAIL toggle_jk got=%b exp=11001100", jk1); end
    @(negedge clk);
    total++; if (bank1 !== 4'b0110 || jk1 !== 8'h00) begin bad++; $display("FAIL toggle_bank bank=%b jk=%b exp 0110 00000000", bank1, jk1); end
    @(negedge clk);
    total++; if (done1 !== 1'b1 || err1 !== 1'b0) begin bad++; $display("FAIL toggle_done done=%b err=%b exp 1 0", done1, err1); end
    @(negedge clk);
  endtask
  task automatic test_mismatch;
    stuck0 = 4'b0001;
    push0(4'b0001);
    @(negedge clk);
    total++; if (jk0 !== 8'b01000110) begin bad++; $display("FAIL mis_jk got=%b exp=01000110", jk0); end
    @(negedge clk);
    total++; if (bank0 !== 4'b0001 || err0 !== 1'b0) begin bad++; $display("FAIL mis_check bank=%b err=%b exp 0001 0", bank0, err0); end
    @(negedge clk);
    total++; if (err0 !== 1'b1 || done0 !== 1'b0) begin bad++; $display("FAIL mis_err err=%b done=%b exp 1 0", err0, done0); end
    repeat (3) @(negedge clk);
    total++; if (err0 !== 1'b1 || busy0 !== 1'b1 || jk0 !== 8'h00 || done0 !== 1'b0) begin bad++; $display("FAIL mis_hold err=%b busy=%b jk=%b done=%b exp 1 1 00000000 0", err0, busy0, jk0, done0); end
    clr0 = 1'b1;
    @(negedge clk);
    clr0 = 1'b0;
    total++; if (err0 !== 1'b0 || busy0 !== 1'b0) begin bad++; $display("FAIL mis_clr err=%b busy=%b exp 0 0", err0, busy0); end
    stuck0 = 4'b0000;
  endtask
  task automatic test_fifo_full;
    logic [3:0] w [5];
    int n, last;
    w[0] = 4'b0011; w[1] = 4'b0110; w[2] = 4'b1100; w[3] = 4'b1000; w[4] = 4'b0101;
    stuck0 = 4'b0001;
    push0(4'b0001);
    repeat (3) @(negedge clk);
    total++; if (err0 !== 1'b1) begin bad++; $display("FAIL full_stall err=%b exp=1", err0); end
    for (int k = 0; k < 5; k++) begin
      total++; if (rdy0 !== (k < 4)) begin bad++; $display("FAIL full_ready%0d got=%b exp=%b", k, rdy0, k < 4); end
      v0 = 1'b1; d0 = w[k];
      @(negedge clk);
    end
    v0 = 1'b0;
    total++; if (rdy0 !== 1'b0) begin bad++; $display("FAIL full_ready_end got=%b exp=0", rdy0); end
    stuck0 = 4'b0000;
    clr0 = 1'b1;
    @(negedge clk);
    clr0 = 1'b0;
    n = 0; last = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done0) begin
        total++; if (n >= 4 || bank0 !== w[n]) begin bad++; $display("FAIL full_order%0d bank=%b exp=%b", n, bank0, n < 4 ? w[n] : 4'bx); end
        if (n > 0) begin
          total++; if (c - last !== 3) begin bad++; $display("FAIL full_rate%0d gap=%0d exp=3", n, c - last); end
        end
        last = c;
        n++;
      end
    end
    total++; if (n !== 4 || bank0 !== 4'b1000 || rdy0 !== 1'b1 || busy0 !== 1'b0) begin bad++; $display("FAIL full_end dones=%0d bank=%b rdy=%b busy=%b exp 4 1000 1 0", n, bank0, rdy0, busy0); end
  endtask
  initial begin
    rst_n = 1'b0;
    v0 = 1'b0; d0 = '0; clr0 = 1'b0; bld0 = 1'b1; bval0 = 4'b0000; stuck0 = 4'b0000;
    v1 = 1'b0; d1 = '0; bld1 = 1'b1; bval1 = 4'b0000;
    repeat (2) @(negedge clk);
    bld0 = 1'b0; bld1 = 1'b0;
    test_reset;
    test_basic;
    test_hold;
    test_toggle;
    test_mismatch;
    test_fifo_full;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
